// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the SR-latch command front end: state encoding
// and default timing constants.
package sr_cmd_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE_S = 2'd1;
  localparam logic [1:0] ST_PULSE_R = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  // Debounce window and pulse width used when the instantiator does not override them.
  localparam int DB_CYCLES_DEF    = 16;
  localparam int PULSE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PULSE_S = ST_PULSE_S,
    PULSE_R = ST_PULSE_R,
    GAP     = ST_GAP
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchroniser, counter-based debounce and
// press-edge detector. The debounced level only flips after the synchronised
// input has disagreed with it for DB_CYCLES consecutive cycles.
module btn_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic       sync_1;
  logic       sync;
  logic       db;
  logic       db_d;
  logic [7:0] cnt;

  // Synchronise, debounce and delay the debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync   <= 1'b0;
      db     <= 1'b0;
      db_d   <= 1'b0;
      cnt    <= 8'd0;
    end else begin
      sync_1 <= btn;
      sync   <= sync_1;
      db_d   <= db;
      if (sync == db) begin
        cnt <= 8'd0;
      end else if (cnt == 8'(DB_CYCLES - 1)) begin
        db  <= sync;
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign level = db;
  // Only presses matter; releases are deliberately ignored.
  assign rise  = db & ~db_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two raw buttons into clean, mutually exclusive fixed-width S/R pulses
// for the SR latch. Simultaneous presses and presses while a pulse (or its
// trailing gap) is in progress are dropped and flagged on conflict.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_s,
  input  logic btn_r,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  logic       rise_s;
  logic       rise_r;
  // Debounced levels are not needed here; the press edges carry everything.
  logic       level_s_unused;
  logic       level_r_unused;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] pc_q;
  logic [7:0] pc_d;
  logic       conflict_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_s (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_s),
    .level (level_s_unused),
    .rise  (rise_s)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_r),
    .level (level_r_unused),
    .rise  (rise_r)
  );

  // Next-state, pulse counter and drop-flag decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s && rise_r) begin
          conflict_d = 1'b1;
        end else if (rise_s) begin
          state_d = PULSE_S;
          pc_d    = 8'd0;
        end else if (rise_r) begin
          state_d = PULSE_R;
          pc_d    = 8'd0;
        end
      end
      PULSE_S, PULSE_R: begin
        conflict_d = rise_s | rise_r;
        if (pc_q == 8'(PULSE_CYCLES - 1)) begin
          state_d = GAP;
          pc_d    = 8'd0;
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      GAP: begin
        conflict_d = rise_s | rise_r;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        pc_d    = 8'd0;
      end
    endcase
  end

  // State register plus outputs registered from the next state, so S and R
  // follow the state exactly and can never be high together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= 8'd0;
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      S        <= (state_d == PULSE_S);
      R        <= (state_d == PULSE_R);
      busy     <= (state_d != IDLE);
      conflict <= conflict_d;
    end
  end

endmodule
